sprite_collision_detector: RTL

- Consumer end of the sprite hit interface. Takes the per-pixel `o_sprite_hit` flags from N object sprites (coins, obstacles) and the player sprite's hit flag.
- Counts player/object pixel overlaps over one frame. At frame end, emits one collision event per hit object over a valid/ready handshake to game logic.
- Maintains a saturating score.
- Sits between the sprite renderers and the game-state controller, in the pixel clock domain.

---
 rtl/sprite_collision_detector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sprite_collision_detector.sv
// Sprite collision detector.
// Counts player/object pixel overlaps per frame. At frame end it reports one
// event per hit object, lowest index first, over a valid/ready handshake. It
// also keeps a saturating score of accepted events.
// Optional build macro COLLISION_COOLDOWN_EN adds a per-object cooldown. After
// an object's event is accepted, that object is suppressed for COOLDOWN_FRAMES
// frame ends.
module sprite_collision_detector #(
  parameter int N_OBJ           = 4,
  parameter int HIT_MIN         = 8,
  parameter int SCORE_W         = 16,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_v_sync,
  input  logic               i_de,
  input  logic               i_player_hit,
  input  logic [N_OBJ-1:0]   i_obj_hit,
  output logic               o_evt_valid,
  input  logic               i_evt_ready,
  output logic [2:0]         o_evt_id,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_overrun,
  output logic [15:0]        o_frame_cnt
);

  typedef enum logic {ST_ACCUM, ST_REPORT} state_t;

  state_t             state_q, state_d;
  logic               vs_s1_q, vs_s2_q, vs_s3_q;
  logic               frame_end;
  logic [7:0]         cnt_q [N_OBJ];
  logic [7:0]         cnt_d [N_OBJ];
  logic [7:0]         cnt_inc [N_OBJ];
  logic [N_OBJ-1:0]   hit_mask;
  logic [N_OBJ-1:0]   pend_q, pend_d, pend_rem;
  logic               evt_valid_q, evt_valid_d;
  logic [2:0]         evt_id_q, evt_id_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               overrun_q, overrun_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               accept;

`ifdef COLLISION_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  logic [CD_W-1:0] cd_q [N_OBJ];
  logic [CD_W-1:0] cd_d [N_OBJ];
`else
  // Cooldown parameter has no effect when the feature is compiled out.
  logic unused_cooldown;
  assign unused_cooldown = ^32'(COOLDOWN_FRAMES);
`endif

  // Index of the lowest set bit; the caller guarantees the mask is nonzero.
  function automatic logic [2:0] lowest_idx(input logic [N_OBJ-1:0] m);
    lowest_idx = '0;
    for (int k = N_OBJ - 1; k >= 0; k--)
      if (m[k]) lowest_idx = 3'(k);
  endfunction

  // Score increment that sticks at all ones.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    sat_inc = (&s) ? s : s + 1'b1;
  endfunction

  // Frame end is a one-cycle pulse on the synchronised rising edge of v_sync.
  assign frame_end = vs_s2_q & ~vs_s3_q;
  assign accept    = evt_valid_q & i_evt_ready;

  // Next-state logic for counters, masks, handshake and score.
  always_comb begin
    frame_cnt_d = frame_cnt_q + 16'(frame_end);
    hit_mask    = '0;
    pend_rem    = pend_q;
    score_d     = score_q;
    for (int k = 0; k < N_OBJ; k++) begin
      cnt_inc[k] = cnt_q[k];
      if (i_de && i_player_hit && i_obj_hit[k] && (cnt_q[k] != 8'hFF))
        cnt_inc[k] = cnt_q[k] + 8'd1;
      // The overlap seen in the frame-end cycle itself still counts.
      hit_mask[k] = frame_end && (cnt_inc[k] >= 8'(HIT_MIN));
      cnt_d[k]    = frame_end ? 8'd0 : cnt_inc[k];
      if (accept && (evt_id_q == 3'(k)))
        pend_rem[k] = 1'b0;
    end
`ifdef COLLISION_COOLDOWN_EN
    for (int k = 0; k < N_OBJ; k++) begin
      cd_d[k] = cd_q[k];
      if (cd_q[k] != '0) begin
        hit_mask[k] = 1'b0;
        if (frame_end) cd_d[k] = cd_q[k] - 1'b1;
      end
      if (accept && (evt_id_q == 3'(k)))
        cd_d[k] = CD_W'(COOLDOWN_FRAMES);
    end
`endif
    if (accept)
      score_d = sat_inc(score_q);

    state_d     = state_q;
    pend_d      = pend_rem;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    overrun_d   = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (|hit_mask) begin
          state_d     = ST_REPORT;
          pend_d      = hit_mask;
          evt_valid_d = 1'b1;
          evt_id_d    = lowest_idx(hit_mask);
        end
      end
      default: begin
        if (pend_rem != '0) begin
          // Still busy: a new frame's hits are dropped and flagged.
          evt_id_d  = lowest_idx(pend_rem);
          overrun_d = |hit_mask;
        end else if (|hit_mask) begin
          // Final accept and frame end in the same cycle: the new frame is
          // handled as if it had arrived in ACCUM.
          pend_d      = hit_mask;
          evt_valid_d = 1'b1;
          evt_id_d    = lowest_idx(hit_mask);
        end else begin
          state_d     = ST_ACCUM;
          evt_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      state_q     <= ST_ACCUM;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      score_q     <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < N_OBJ; k++) cnt_q[k] <= '0;
`ifdef COLLISION_COOLDOWN_EN
      for (int k = 0; k < N_OBJ; k++) cd_q[k] <= '0;
`endif
    end else begin
      vs_s1_q     <= i_v_sync;
      vs_s2_q     <= vs_s1_q;
      vs_s3_q     <= vs_s2_q;
      state_q     <= state_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      score_q     <= score_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < N_OBJ; k++) cnt_q[k] <= cnt_d[k];
`ifdef COLLISION_COOLDOWN_EN
      for (int k = 0; k < N_OBJ; k++) cd_q[k] <= cd_d[k];
`endif
    end
  end

  assign o_evt_valid = evt_valid_q;
  assign o_evt_id    = evt_id_q;
  assign o_score     = score_q;
  assign o_overrun   = overrun_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule
